// File: rtl/video_sync_gen.sv
// Raster timing generator: free-running pixel/line counters with a registered
// decode of sync, data-enable and active-area coordinates, one pixel per clock.
module video_sync_gen #(
  parameter int   H_ACTIVE = 1366,
  parameter int   H_FP     = 70,
  parameter int   H_SYNC   = 143,
  parameter int   H_BP     = 213,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 24,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_en,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 1024 ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
    $fatal(1, "video_sync_gen: illegal timing parameters");
  end

  // Boundaries fit the counter widths once the totals pass the check above.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG_W = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END_W = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG_W = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END_W = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hc_r;
  logic [9:0]  vc_r;
  logic [10:0] hc_next_s;
  logic [9:0]  vc_next_s;
  logic        hc_wrap_s;
  logic        vc_wrap_s;

  logic        hsync_s;
  logic        vsync_s;
  logic        de_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;
  logic        frame_start_s;

  logic        hsync_r;
  logic        vsync_r;
  logic        de_r;
  logic [10:0] x_r;
  logic [9:0]  y_r;
  logic        frame_start_r;

  // Next counter values; the line counter only moves when the pixel counter wraps.
  always_comb begin
    hc_wrap_s = (hc_r == H_LAST);
    vc_wrap_s = (vc_r == V_LAST);
    if (hc_wrap_s) begin
      hc_next_s = 11'd0;
    end else begin
      hc_next_s = hc_r + 11'd1;
    end
    if (!hc_wrap_s) begin
      vc_next_s = vc_r;
    end else if (vc_wrap_s) begin
      vc_next_s = 10'd0;
    end else begin
      vc_next_s = vc_r + 10'd1;
    end
  end

  // Output decode from the current (pre-update) counters; disabled means idle levels.
  always_comb begin
    hsync_s       = ~H_POL;
    vsync_s       = ~V_POL;
    de_s          = 1'b0;
    x_s           = 11'd0;
    y_s           = 10'd0;
    frame_start_s = 1'b0;
    if (i_en) begin
      de_s          = (hc_r < H_ACT_W) && (vc_r < V_ACT_W);
      hsync_s       = ((hc_r >= HS_BEG_W) && (hc_r < HS_END_W)) ? H_POL : ~H_POL;
      vsync_s       = ((vc_r >= VS_BEG_W) && (vc_r < VS_END_W)) ? V_POL : ~V_POL;
      x_s           = de_s ? hc_r : 11'd0;
      y_s           = de_s ? vc_r : 10'd0;
      frame_start_s = (hc_r == 11'd0) && (vc_r == 10'd0);
    end else begin
      frame_start_s = 1'b0;
    end
  end

  // Counter state: disabling parks the raster at (0,0) so re-enable starts a fresh frame.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      hc_r <= 11'd0;
      vc_r <= 10'd0;
    end else if (i_en) begin
      hc_r <= hc_next_s;
      vc_r <= vc_next_s;
    end else begin
      hc_r <= 11'd0;
      vc_r <= 10'd0;
    end
  end

  // Output registers, one clock behind the counters and mutually aligned.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      hsync_r       <= ~H_POL;
      vsync_r       <= ~V_POL;
      de_r          <= 1'b0;
      x_r           <= 11'd0;
      y_r           <= 10'd0;
      frame_start_r <= 1'b0;
    end else begin
      hsync_r       <= hsync_s;
      vsync_r       <= vsync_s;
      de_r          <= de_s;
      x_r           <= x_s;
      y_r           <= y_s;
      frame_start_r <= frame_start_s;
    end
  end

  assign o_hsync       = hsync_r;
  assign o_vsync       = vsync_r;
  assign o_de          = de_r;
  assign o_x           = x_r;
  assign o_y           = y_r;
  assign o_frame_start = frame_start_r;

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench for video_sync_gen: default 1366x768 line timing, a tiny
// 14x7 raster for frame/wrap/enable checks, and an inverted-polarity reset check.
module tb_video_sync_gen;

  logic clk;
  logic rst_n;
  logic en_def, en_small, en_neg;

  logic        hs_def, vs_def, de_def, fs_def;
  logic [10:0] x_def;
  logic [9:0]  y_def;
  logic        hs_sm, vs_sm, de_sm, fs_sm;
  logic [10:0] x_sm;
  logic [9:0]  y_sm;
  logic        hs_neg, vs_neg, de_neg, fs_neg;
  logic [10:0] x_neg;
  logic [9:0]  y_neg;

  int n_cmp;
  int n_bad;

  video_sync_gen u_def (
    .i_clk(clk), .i_nrst(rst_n), .i_en(en_def),
    .o_hsync(hs_def), .o_vsync(vs_def), .o_de(de_def),
    .o_x(x_def), .o_y(y_def), .o_frame_start(fs_def)
  );

  video_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .i_clk(clk), .i_nrst(rst_n), .i_en(en_small),
    .o_hsync(hs_sm), .o_vsync(vs_sm), .o_de(de_sm),
    .o_x(x_sm), .o_y(y_sm), .o_frame_start(fs_sm)
  );

  video_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_neg (
    .i_clk(clk), .i_nrst(rst_n), .i_en(en_neg),
    .o_hsync(hs_neg), .o_vsync(vs_neg), .o_de(de_neg),
    .o_x(x_neg), .o_y(y_neg), .o_frame_start(fs_neg)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; en_def = 1'b0; en_small = 1'b0; en_neg = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (hs_def !== 1'b0) begin n_bad++; $display("FAIL reset_hsync: got %b want 0", hs_def); end
    n_cmp++; if (vs_def !== 1'b0) begin n_bad++; $display("FAIL reset_vsync: got %b want 0", vs_def); end
    n_cmp++; if (de_def !== 1'b0) begin n_bad++; $display("FAIL reset_de: got %b want 0", de_def); end
    n_cmp++; if (x_def !== 11'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", x_def); end
    n_cmp++; if (y_def !== 10'd0) begin n_bad++; $display("FAIL reset_y: got %0d want 0", y_def); end
    n_cmp++; if (fs_def !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b want 0", fs_def); end
    n_cmp++; if (hs_neg !== 1'b1) begin n_bad++; $display("FAIL reset_hsync_neg: got %b want 1", hs_neg); end
    n_cmp++; if (vs_neg !== 1'b1) begin n_bad++; $display("FAIL reset_vsync_neg: got %b want 1", vs_neg); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_line();
    int de_hi, de_lo, hs_cnt, hs_first, x_err, fs_cnt, vs_cnt;
    de_hi = 0; de_lo = 0; hs_cnt = 0; hs_first = -1; x_err = 0; fs_cnt = 0; vs_cnt = 0;
    en_def = 1'b1;
    for (int k = 0; k <= 1792; k++) begin
      @(negedge clk);
      if (k < 1792) begin
        if (de_def === 1'b1) de_hi++; else de_lo++;
        if (hs_def === 1'b1) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k;
        end
        if (vs_def === 1'b1) vs_cnt++;
        if (fs_def === 1'b1) fs_cnt++;
        if (int'(x_def) != ((k < 1366) ? k : 0)) x_err++;
      end else begin
        n_cmp++; if (de_def !== 1'b1 || x_def !== 11'd0 || y_def !== 10'd1) begin
          n_bad++; $display("FAIL line_period: got de=%b x=%0d y=%0d want de=1 x=0 y=1", de_def, x_def, y_def);
        end
      end
    end
    n_cmp++; if (de_hi != 1366) begin n_bad++; $display("FAIL line_de_high: got %0d want 1366", de_hi); end
    n_cmp++; if (de_lo != 426) begin n_bad++; $display("FAIL line_de_low: got %0d want 426", de_lo); end
    n_cmp++; if (x_err != 0) begin n_bad++; $display("FAIL line_x_steps: got %0d bad cycles want 0", x_err); end
    n_cmp++; if (hs_cnt != 143) begin n_bad++; $display("FAIL line_hsync_width: got %0d want 143", hs_cnt); end
    n_cmp++; if (hs_first != 1436) begin n_bad++; $display("FAIL line_hsync_start: got %0d want 1436", hs_first); end
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL line_fs_count: got %0d want 1", fs_cnt); end
    n_cmp++; if (vs_cnt != 0) begin n_bad++; $display("FAIL line_vsync: got %0d want 0", vs_cnt); end
    en_def = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame();
    int de_cnt, de_wrong, y_err, y_max, vs_cnt, vs_first, fs_cnt, hs_cnt;
    de_cnt = 0; de_wrong = 0; y_err = 0; y_max = 0; vs_cnt = 0; vs_first = -1; fs_cnt = 0; hs_cnt = 0;
    en_small = 1'b1;
    for (int k = 0; k <= 98; k++) begin
      @(negedge clk);
      if (k < 98) begin
        if (fs_sm === 1'b1) fs_cnt++;
        if (hs_sm === 1'b1) hs_cnt++;
        if (vs_sm === 1'b1) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = k;
        end
        if (de_sm === 1'b1) begin
          de_cnt++;
          if ((k / 14) > 3 || (k % 14) > 7) de_wrong++;
          if (int'(y_sm) != k / 14) y_err++;
          if (int'(y_sm) > y_max) y_max = int'(y_sm);
        end
      end else begin
        n_cmp++; if (fs_sm !== 1'b1) begin n_bad++; $display("FAIL frame_period: got fs=%b want 1 at clk 98", fs_sm); end
      end
    end
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL frame_fs_count: got %0d want 1", fs_cnt); end
    n_cmp++; if (vs_cnt != 14) begin n_bad++; $display("FAIL frame_vsync_width: got %0d want 14", vs_cnt); end
    n_cmp++; if (vs_first != 70) begin n_bad++; $display("FAIL frame_vsync_start: got %0d want 70", vs_first); end
    n_cmp++; if (hs_cnt != 14) begin n_bad++; $display("FAIL frame_hsync_count: got %0d want 14", hs_cnt); end
    n_cmp++; if (de_cnt != 32) begin n_bad++; $display("FAIL frame_de_count: got %0d want 32", de_cnt); end
    n_cmp++; if (de_wrong != 0) begin n_bad++; $display("FAIL frame_de_lines: got %0d stray want 0", de_wrong); end
    n_cmp++; if (y_err != 0) begin n_bad++; $display("FAIL frame_y_steps: got %0d bad want 0", y_err); end
    n_cmp++; if (y_max != 3) begin n_bad++; $display("FAIL frame_y_max: got %0d want 3", y_max); end
    en_small = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enable();
    int budget;
    bit found;
    budget = 0; found = 1'b0;
    en_small = 1'b1;
    while (!found && budget < 200) begin
      @(negedge clk);
      budget++;
      if (de_sm === 1'b1 && x_sm === 11'd5) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL enable_reach_x5: got timeout want x=5 within 200 clks"); end
    en_small = 1'b0;
    @(negedge clk);
    n_cmp++; if (hs_sm !== 1'b0 || vs_sm !== 1'b0 || de_sm !== 1'b0) begin
      n_bad++; $display("FAIL enable_off_sync: got hs=%b vs=%b de=%b want 0 0 0", hs_sm, vs_sm, de_sm);
    end
    n_cmp++; if (x_sm !== 11'd0 || y_sm !== 10'd0 || fs_sm !== 1'b0) begin
      n_bad++; $display("FAIL enable_off_xy: got x=%0d y=%0d fs=%b want 0 0 0", x_sm, y_sm, fs_sm);
    end
    @(negedge clk);
    en_small = 1'b1;
    @(negedge clk);
    n_cmp++; if (fs_sm !== 1'b1 || de_sm !== 1'b1 || x_sm !== 11'd0 || y_sm !== 10'd0) begin
      n_bad++; $display("FAIL enable_resume: got fs=%b de=%b x=%0d y=%0d want 1 1 0 0", fs_sm, de_sm, x_sm, y_sm);
    end
    en_small = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    en_def = 1'b1;
    repeat (101) @(negedge clk);
    n_cmp++; if (de_def !== 1'b1 || x_def !== 11'd100) begin
      n_bad++; $display("FAIL areset_pre: got de=%b x=%0d want 1 100", de_def, x_def);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (de_def !== 1'b0 || x_def !== 11'd0 || y_def !== 10'd0) begin
      n_bad++; $display("FAIL areset_immediate: got de=%b x=%0d y=%0d want 0 0 0", de_def, x_def, y_def);
    end
    n_cmp++; if (hs_def !== 1'b0 || vs_def !== 1'b0 || fs_def !== 1'b0) begin
      n_bad++; $display("FAIL areset_sync: got hs=%b vs=%b fs=%b want 0 0 0", hs_def, vs_def, fs_def);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (fs_def !== 1'b1 || de_def !== 1'b1 || x_def !== 11'd0 || y_def !== 10'd0) begin
      n_bad++; $display("FAIL areset_restart: got fs=%b de=%b x=%0d y=%0d want 1 1 0 0", fs_def, de_def, x_def, y_def);
    end
    en_def = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int fs_cnt, fs_second;
    fs_cnt = 0; fs_second = -1;
    en_small = 1'b1;
    for (int k = 0; k < 196; k++) begin
      @(negedge clk);
      if (fs_sm === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 2) fs_second = k;
      end
      if (k == 49) begin
        n_cmp++; if (de_sm !== 1'b1 || x_sm !== 11'd7 || y_sm !== 10'd3) begin
          n_bad++; $display("FAIL wrap_last_pixel: got de=%b x=%0d y=%0d want 1 7 3", de_sm, x_sm, y_sm);
        end
      end
      if (k == 97) begin
        n_cmp++; if (de_sm !== 1'b0 || fs_sm !== 1'b0) begin
          n_bad++; $display("FAIL wrap_last_clk: got de=%b fs=%b want 0 0", de_sm, fs_sm);
        end
      end
      if (k == 98) begin
        n_cmp++; if (fs_sm !== 1'b1 || de_sm !== 1'b1 || x_sm !== 11'd0 || y_sm !== 10'd0) begin
          n_bad++; $display("FAIL wrap_origin: got fs=%b de=%b x=%0d y=%0d want 1 1 0 0", fs_sm, de_sm, x_sm, y_sm);
        end
      end
    end
    n_cmp++; if (fs_cnt != 2) begin n_bad++; $display("FAIL wrap_fs_count: got %0d want 2", fs_cnt); end
    n_cmp++; if (fs_second != 98) begin n_bad++; $display("FAIL wrap_fs_spacing: got %0d want 98", fs_second); end
    en_small = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_line();
    test_frame();
    test_enable();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
